// File: rtl/tnn_pkg.sv
// Shared types and helpers for the tempotron neural network blocks.
// Holds the STDP FSM/rule enums and the thermometer encoder used by the neuron column.
package tnn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StUpdate,
        StDone
    } stdp_state_t;

    typedef enum logic [1:0] {
        RuleNone,
        RuleCapture,
        RuleBackoff,
        RuleSearch
    } stdp_rule_t;

    localparam int unsigned ThermMax = 32;

    // Bit k is set when k >= w; bits at or above wmax are left clear.
    function automatic logic [ThermMax-1:0] therm_encode(input int unsigned w,
                                                         input int unsigned wmax);
        logic [ThermMax-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < ThermMax; k++) begin
            t[k] = (k < wmax) && (k >= w);
        end
        return t;
    endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One synapse of the STDP stage: input edge detector, ordering flags, rule decode
// and a saturating weight counter presented thermometer-coded.
module stdp_synapse
    import tnn_pkg::*;
#(
    parameter int unsigned WMAX   = 7,
    parameter int unsigned W_INIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            collect,
    input  logic            apply,
    input  logic            in_spike,
    input  logic            out_seen,
    input  logic            brv_capture,
    input  logic            brv_backoff,
    input  logic            brv_search,
    output logic [WMAX-1:0] weight
);

    localparam int unsigned WW = $clog2(WMAX + 1);

    logic          in_prev_q;
    logic          in_seen_q;
    logic          in_first_q;
    logic [WW-1:0] w_q;
    logic [WW-1:0] w_d;
    logic          in_event;
    stdp_rule_t    rule;

    assign in_event = in_prev_q & ~in_spike;

    always_comb begin
        rule = RuleNone;
        if (in_seen_q && out_seen && in_first_q) begin
            rule = RuleCapture;
        end else if (out_seen) begin
            rule = RuleBackoff;
        end else if (in_seen_q) begin
            rule = RuleSearch;
        end
    end

    always_comb begin
        w_d = w_q;
        unique case (rule)
            RuleCapture: if (brv_capture && (w_q != WW'(WMAX))) w_d = w_q + 1'b1;
            RuleBackoff: if (brv_backoff && (w_q != '0))        w_d = w_q - 1'b1;
            RuleSearch:  if (brv_search  && (w_q != WW'(WMAX))) w_d = w_q + 1'b1;
            RuleNone:    w_d = w_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_prev_q  <= 1'b1;
            in_seen_q  <= 1'b0;
            in_first_q <= 1'b0;
            w_q        <= WW'(W_INIT);
        end else begin
            in_prev_q <= in_spike;
            if (clear) begin
                in_seen_q  <= 1'b0;
                in_first_q <= 1'b0;
            end else if (collect && in_event && !in_seen_q) begin
                // An output event in this same cycle is not yet in out_seen, so it counts as first.
                in_seen_q  <= 1'b1;
                in_first_q <= ~out_seen;
            end
            if (apply) begin
                w_q <= w_d;
            end
        end
    end

    assign weight = WMAX'(therm_encode(32'(w_q), WMAX));

endmodule

// File: rtl/stdp_weight_update.sv
// Stochastic STDP weight update for one neuron: collects spike ordering over a gamma
// cycle, then applies Bernoulli-gated capture/backoff/search to each synapse's weight.
module stdp_weight_update
    import tnn_pkg::*;
#(
    parameter int unsigned SYNAPSES = 8,
    parameter int unsigned WMAX     = 7,
    parameter int unsigned W_INIT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     gamma_start,
    input  logic                     gamma_end,
    input  logic                     learn_en,
    input  logic [SYNAPSES-1:0]      in_spike,
    input  logic                     out_spike,
    input  logic [SYNAPSES-1:0]      brv_capture,
    input  logic [SYNAPSES-1:0]      brv_backoff,
    input  logic [SYNAPSES-1:0]      brv_search,
    output logic [SYNAPSES*WMAX-1:0] weight,
    output logic                     busy,
    output logic                     update_done
);

    stdp_state_t state_q;
    logic        out_prev_q;
    logic        out_seen_q;
    logic        out_event;
    logic        clear;
    logic        collect;
    logic        apply;

    assign out_event = out_prev_q & ~out_spike;

    // Entering COLLECT, either from IDLE or as a restart; gamma_end beats a restart.
    assign clear   = gamma_start && ((state_q == StIdle) ||
                                     ((state_q == StCollect) && !gamma_end));
    assign collect = (state_q == StCollect) && !clear;
    assign apply   = (state_q == StUpdate) && learn_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            update_done <= 1'b0;
            out_prev_q  <= 1'b1;
            out_seen_q  <= 1'b0;
        end else begin
            out_prev_q  <= out_spike;
            update_done <= 1'b0;
            if (clear) begin
                out_seen_q <= 1'b0;
            end else if (collect && out_event) begin
                out_seen_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (gamma_start) begin
                        state_q <= StCollect;
                        busy    <= 1'b1;
                    end
                end
                StCollect: begin
                    if (gamma_end) begin
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    state_q     <= StDone;
                    busy        <= 1'b0;
                    update_done <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    for (genvar i = 0; i < SYNAPSES; i++) begin : g_syn
        stdp_synapse #(
            .WMAX   (WMAX),
            .W_INIT (W_INIT)
        ) u_syn (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .collect     (collect),
            .apply       (apply),
            .in_spike    (in_spike[i]),
            .out_seen    (out_seen_q),
            .brv_capture (brv_capture[i]),
            .brv_backoff (brv_backoff[i]),
            .brv_search  (brv_search[i]),
            .weight      (weight[i*WMAX +: WMAX])
        );
    end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Directed bench for stdp_weight_update: table of gamma-cycle vectors plus hand-written
// sequences for restart, simultaneous gamma pulses, dropped pulses and reset mid-update.
module tb_stdp_weight_update;

    localparam logic [3:0] NO = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        gamma_start;
    logic        gamma_end;
    logic        learn_en;
    logic [7:0]  in_spike;
    logic        out_spike;
    logic [7:0]  brv_c;
    logic [7:0]  brv_b;
    logic [7:0]  brv_s;
    logic [55:0] weight;
    logic        busy;
    logic        update_done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0][3:0] in_t;
        logic [3:0]      out_t;
        logic [3:0]      len;
        logic [7:0]      bc;
        logic [7:0]      bb;
        logic [7:0]      bs;
        logic            learn;
        logic [7:0][2:0] exp_w;
    } vec_t;

    vec_t vecs [14];

    stdp_weight_update #(
        .SYNAPSES (8),
        .WMAX     (7),
        .W_INIT   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gamma_start (gamma_start),
        .gamma_end   (gamma_end),
        .learn_en    (learn_en),
        .in_spike    (in_spike),
        .out_spike   (out_spike),
        .brv_capture (brv_c),
        .brv_backoff (brv_b),
        .brv_search  (brv_s),
        .weight      (weight),
        .busy        (busy),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] therm(input logic [7:0][2:0] w);
        logic [55:0] t;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 7; k++) begin
                t[i*7+k] = (k >= int'(w[i]));
            end
        end
        return t;
    endfunction

    function automatic vec_t mkv(input logic [31:0] in_t, input logic [3:0] out_t,
                                 input logic [3:0] len, input logic [7:0] bc,
                                 input logic [7:0] bb, input logic [7:0] bs,
                                 input logic learn, input logic [23:0] exp_w);
        vec_t v;
        v.in_t  = in_t;
        v.out_t = out_t;
        v.len   = len;
        v.bc    = bc;
        v.bb    = bb;
        v.bs    = bs;
        v.learn = learn;
        v.exp_w = exp_w;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lines_idle();
        in_spike    = '1;
        out_spike   = 1'b1;
        gamma_start = 1'b0;
        gamma_end   = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        gamma_start = 1'b1;
        step();
        gamma_start = 1'b0;
        check($sformatf("v%0d_busy_collect", idx), 64'(busy), 64'd1);
        for (int c = 0; c < int'(v.len); c++) begin
            for (int i = 0; i < 8; i++) begin
                in_spike[i] = !((v.in_t[i] != NO) && (c >= int'(v.in_t[i])));
            end
            out_spike = !((v.out_t != NO) && (c >= int'(v.out_t)));
            gamma_end = (c == int'(v.len) - 1);
            step();
        end
        gamma_end = 1'b0;
        brv_c     = v.bc;
        brv_b     = v.bb;
        brv_s     = v.bs;
        learn_en  = v.learn;
        check($sformatf("v%0d_busy_update", idx), 64'(busy), 64'd1);
        check($sformatf("v%0d_done_early", idx), 64'(update_done), 64'd0);
        step();
        check($sformatf("v%0d_done", idx), 64'(update_done), 64'd1);
        check($sformatf("v%0d_busy_done", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_weight", idx), 64'(weight), 64'(therm(v.exp_w)));
        step();
        lines_idle();
        learn_en = 1'b1;
        check($sformatf("v%0d_done_pulse", idx), 64'(update_done), 64'd0);
        step();
    endtask

    initial begin
        // Weights listed synapse 7 .. synapse 0; fall times are COLLECT cycle indices.
        vecs[0]  = mkv({NO, NO, NO, NO, NO, NO, NO, 4'd2}, 4'd5, 4'd8, 8'hFF, 8'hFF, 8'hFF,
                       1'b1, {3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4});
        vecs[1]  = mkv({4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, NO, 4'd8, 8'hFF,
                       8'hFF, 8'hF3, 1'b1, {3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd3, 3'd5});
        vecs[2]  = mkv({4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, NO, 4'd8, 8'hFF,
                       8'hFF, 8'h03, 1'b1, {3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd4, 3'd6});
        vecs[3]  = mkv({4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, NO, 4'd8, 8'hFF,
                       8'hFF, 8'h03, 1'b1, {3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd5, 3'd7});
        vecs[4]  = mkv({4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, NO, 4'd8, 8'hFF,
                       8'hFF, 8'h03, 1'b1, {3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd6, 3'd7});
        vecs[5]  = mkv({4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, NO, 4'd8, 8'hFF,
                       8'hFF, 8'h02, 1'b1, {3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd7, 3'd7});
        vecs[6]  = mkv({4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, NO, 4'd8, 8'hFF,
                       8'hFF, 8'h02, 1'b1, {3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd7, 3'd7});
        vecs[7]  = mkv({NO, NO, NO, NO, NO, 4'd4, NO, NO}, 4'd3, 4'd8, 8'hFF, 8'hFF, 8'hFF,
                       1'b1, {3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd6, 3'd6});
        vecs[8]  = mkv({NO, NO, NO, NO, NO, 4'd4, NO, NO}, 4'd3, 4'd8, 8'hFF, 8'h04, 8'hFF,
                       1'b1, {3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd6, 3'd6});
        vecs[9]  = mkv({NO, NO, NO, NO, NO, 4'd4, NO, NO}, 4'd3, 4'd8, 8'hFF, 8'h04, 8'hFF,
                       1'b1, {3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd6, 3'd6});
        vecs[10] = mkv({NO, NO, 4'd1, 4'd6, 4'd4, NO, NO, NO}, 4'd4, 4'd8, 8'hFF, 8'h10, 8'hFF,
                       1'b1, {3'd2, 3'd2, 3'd3, 3'd1, 3'd2, 3'd0, 3'd6, 3'd6});
        vecs[11] = mkv({NO, 4'd0, NO, NO, NO, NO, NO, NO}, 4'd3, 4'd8, 8'hFF, 8'hFF, 8'hFF,
                       1'b0, {3'd2, 3'd2, 3'd3, 3'd1, 3'd2, 3'd0, 3'd6, 3'd6});
        vecs[12] = mkv({NO, NO, NO, NO, NO, NO, NO, NO}, NO, 4'd8, 8'hFF, 8'hFF, 8'hFF,
                       1'b1, {3'd2, 3'd2, 3'd3, 3'd1, 3'd2, 3'd0, 3'd6, 3'd6});
        vecs[13] = mkv({4'd0, NO, NO, NO, NO, NO, NO, NO}, 4'd2, 4'd8, 8'h00, 8'hFF, 8'hFF,
                       1'b1, {3'd2, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0, 3'd5, 3'd5});

        rst      = 1'b1;
        lines_idle();
        brv_c    = '0;
        brv_b    = '0;
        brv_s    = '0;
        learn_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_weight", 64'(weight), 64'(therm({8{3'd3}})));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(update_done), 64'd0);
        repeat (3) step();
        check("idle_weight", 64'(weight), 64'(therm({8{3'd3}})));
        check("idle_busy", 64'(busy), 64'd0);

        for (int v = 0; v < 14; v++) begin
            run_vec(v, vecs[v]);
        end

        // Restart mid-collection discards the earlier input event on synapse 0.
        gamma_start = 1'b1;
        step();
        gamma_start = 1'b0;
        step();
        in_spike[0] = 1'b0;
        step();
        step();
        gamma_start = 1'b1;
        step();
        gamma_start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        step();
        out_spike = 1'b0;
        step();
        gamma_end = 1'b1;
        step();
        gamma_end = 1'b0;
        brv_c = 8'hFF;
        brv_b = 8'h01;
        brv_s = 8'hFF;
        step();
        check("restart_done", 64'(update_done), 64'd1);
        check("restart_weight", 64'(weight),
              64'(therm({3'd2, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0, 3'd5, 3'd4})));
        step();
        lines_idle();
        step();

        // gamma_start and gamma_end together in COLLECT; gamma_start in UPDATE is dropped.
        gamma_start = 1'b1;
        step();
        gamma_start = 1'b0;
        in_spike[1] = 1'b0;
        step();
        step();
        gamma_start = 1'b1;
        gamma_end   = 1'b1;
        step();
        gamma_end = 1'b0;
        check("both_busy_update", 64'(busy), 64'd1);
        brv_c = 8'hFF;
        brv_b = 8'hFF;
        brv_s = 8'h02;
        step();
        gamma_start = 1'b0;
        check("both_done", 64'(update_done), 64'd1);
        check("both_weight", 64'(weight),
              64'(therm({3'd2, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0, 3'd6, 3'd4})));
        step();
        lines_idle();
        check("both_idle_busy", 64'(busy), 64'd0);
        check("both_idle_done", 64'(update_done), 64'd0);
        step();
        check("drop_start_idle", 64'(busy), 64'd0);

        // An input event in the gamma_start cycle is not recorded.
        gamma_start = 1'b1;
        in_spike[2] = 1'b0;
        step();
        gamma_start = 1'b0;
        repeat (3) step();
        gamma_end = 1'b1;
        step();
        gamma_end = 1'b0;
        brv_s = 8'hFF;
        step();
        check("start_evt_done", 64'(update_done), 64'd1);
        check("start_evt_weight", 64'(weight),
              64'(therm({3'd2, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0, 3'd6, 3'd4})));
        step();
        lines_idle();
        step();

        // gamma_end while IDLE is ignored.
        gamma_end = 1'b1;
        step();
        gamma_end = 1'b0;
        check("end_idle_busy", 64'(busy), 64'd0);
        step();
        check("end_idle_done", 64'(update_done), 64'd0);
        step();

        // Reset during UPDATE: no update, weights back to W_INIT.
        gamma_start = 1'b1;
        step();
        gamma_start = 1'b0;
        in_spike[1] = 1'b0;
        step();
        gamma_end = 1'b1;
        step();
        gamma_end = 1'b0;
        brv_s    = 8'hFF;
        learn_en = 1'b1;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        lines_idle();
        check("rst_upd_weight", 64'(weight), 64'(therm({8{3'd3}})));
        check("rst_upd_done", 64'(update_done), 64'd0);
        check("rst_upd_busy", 64'(busy), 64'd0);
        step();
        check("rst_upd_done_after", 64'(update_done), 64'd0);
        check("rst_upd_busy_after", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
